// File: rtl/arb4_prio_rr.sv
`default_nettype none
// ============================================================================
// Module   : arb4_prio_rr
// Brief    : Four-requester arbiter with fixed-priority or round-robin
//            selection, registered held grants and a hold timeout.
// Revision : 1.0  initial release
// ============================================================================
module arb4_prio_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    r_state;
    logic [3:0]    r_gnt;
    logic [1:0]    r_gnt_id;
    logic          r_busy;
    logic          r_timeout;
    logic [1:0]    r_last_id;
    logic [3:0]    r_mask;
    logic [CW-1:0] r_hold_cnt;

    logic [3:0]    w_cand;
    logic [1:0]    w_win_id;
    logic [1:0]    w_idx;
    logic          w_found;

    assign w_cand = req & ~r_mask;

    // Round-robin walks downward from the last owner so that owner is tried last.
    always_comb begin
        w_win_id = 2'd0;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        if (!mode) begin
            for (int i = 0; i < 4; i++) begin
                if (w_cand[i]) begin
                    w_win_id = 2'(i);
                end
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                w_idx = r_last_id - 2'(k);
                if (!w_found && w_cand[w_idx]) begin
                    w_win_id = w_idx;
                    w_found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 4'b0000;
            r_gnt_id   <= 2'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_last_id  <= 2'd0;
            r_mask     <= 4'b0000;
            r_hold_cnt <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mask <= 4'b0000;
                    if (|w_cand) begin
                        r_state    <= S_GRANT;
                        r_gnt      <= 4'b0001 << w_win_id;
                        r_gnt_id   <= w_win_id;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= CW'(1);
                    end
                end
                S_GRANT: begin
                    // Release takes precedence over a coincident timeout.
                    if (!req[r_gnt_id]) begin
                        r_state    <= S_IDLE;
                        r_gnt      <= 4'b0000;
                        r_gnt_id   <= 2'd0;
                        r_busy     <= 1'b0;
                        r_last_id  <= r_gnt_id;
                        r_hold_cnt <= '0;
                    end else if ((MAX_HOLD != 0) && (r_hold_cnt == CW'(MAX_HOLD))) begin
                        r_state    <= S_IDLE;
                        r_gnt      <= 4'b0000;
                        r_gnt_id   <= 2'd0;
                        r_busy     <= 1'b0;
                        r_last_id  <= r_gnt_id;
                        r_mask     <= 4'b0001 << r_gnt_id;
                        r_timeout  <= 1'b1;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt < CW'(MAX_HOLD)) begin
                        r_hold_cnt <= r_hold_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_arb4_prio_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb4_prio_rr
// Brief    : Directed scoreboard bench for arb4_prio_rr with MAX_HOLD = 4.
// Revision : 1.0  initial release
// ============================================================================
module tb_arb4_prio_rr;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    string      tag;

    arb4_prio_rr #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh2id(input logic [3:0] oh);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) id = 2'(i);
        end
        return id;
    endfunction

    // One clock: apply inputs, then queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic m, input logic [3:0] rq,
                       input logic [3:0] eg, input logic et);
        @(negedge clk);
        rst  = r;
        mode = m;
        req  = rq;
        @(posedge clk);
        exp_q.push_back({eg, oh2id(eg), |eg, et});
        tag_q.push_back(tag);
    endtask

    // Monitor: compares the DUT outputs mid-cycle against the queued expectations.
    initial begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        string      t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                t     = tag_q.pop_front();
                act_v = {gnt, gnt_id, busy, timeout};
                n_tests++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                             t, act_v[7:4], act_v[3:2], act_v[1], act_v[0],
                             exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        mode = 1'b0;

        tag = "reset";
        cyc(1, 0, 4'b0000, 4'b0000, 0);
        cyc(1, 0, 4'b0000, 4'b0000, 0);

        tag = "fixed";
        cyc(0, 0, 4'b0110, 4'b0100, 0);
        cyc(0, 0, 4'b0110, 4'b0100, 0);
        cyc(0, 0, 4'b0010, 4'b0000, 0);
        cyc(0, 0, 4'b0010, 4'b0010, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);

        tag = "rr_reset";
        cyc(1, 1, 4'b0000, 4'b0000, 0);
        tag = "rr";
        cyc(0, 1, 4'b1111, 4'b1000, 0);
        cyc(0, 1, 4'b1111, 4'b1000, 0);
        cyc(0, 1, 4'b1111, 4'b1000, 0);
        cyc(0, 1, 4'b0111, 4'b0000, 0);
        cyc(0, 1, 4'b1111, 4'b0100, 0);
        cyc(0, 1, 4'b1111, 4'b0100, 0);
        cyc(0, 1, 4'b1111, 4'b0100, 0);
        cyc(0, 1, 4'b1011, 4'b0000, 0);
        cyc(0, 1, 4'b1111, 4'b0010, 0);
        cyc(0, 1, 4'b1111, 4'b0010, 0);
        cyc(0, 1, 4'b1111, 4'b0010, 0);
        cyc(0, 1, 4'b1101, 4'b0000, 0);
        cyc(0, 1, 4'b1111, 4'b0001, 0);
        cyc(0, 1, 4'b1111, 4'b0001, 0);
        cyc(0, 1, 4'b1111, 4'b0001, 0);
        cyc(0, 1, 4'b1110, 4'b0000, 0);
        cyc(0, 1, 4'b1111, 4'b1000, 0);
        cyc(0, 1, 4'b0000, 4'b0000, 0);

        tag = "timeout";
        cyc(0, 0, 4'b1001, 4'b1000, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'b1001, 4'b1000, 0);
        cyc(0, 0, 4'b1001, 4'b0000, 1);
        tag = "masked";
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'b1001, 4'b0001, 0);
        cyc(0, 0, 4'b1001, 4'b0000, 1);
        cyc(0, 0, 4'b1001, 4'b1000, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);

        tag = "collision";
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'b1000, 4'b1000, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);

        tag = "mid_reset";
        cyc(0, 1, 4'b0010, 4'b0010, 0);
        cyc(0, 1, 4'b0000, 4'b0000, 0);
        cyc(0, 1, 4'b0100, 4'b0100, 0);
        cyc(1, 1, 4'b0100, 4'b0000, 0);
        cyc(0, 1, 4'b0000, 4'b0000, 0);
        cyc(0, 1, 4'b1010, 4'b1000, 0);
        cyc(0, 1, 4'b0000, 4'b0000, 0);

        tag = "idle";
        for (int i = 0; i < 20; i++) cyc(0, 0, 4'b0000, 4'b0000, 0);
        tag = "pulse";
        cyc(0, 0, 4'b0001, 4'b0001, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb4_prio_rr.md
Name: arb4_prio_rr

Overview:
- Four-requester arbiter that shares one downstream resource (bus, datapath port, encoder-fed unit) between up to four masters.
- Winner selection reuses the 4-to-2 priority-encoding convention: highest index wins in fixed mode.
- A round-robin mode rotates priority so that the most recently served requester has the lowest priority.
- Grants are registered and held until the owner releases the resource or a hold-timeout expires. The block sits between the requesters and the resource mux select.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold a grant; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1) (min 1), hold counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request vector; req[i] held high while requester i wants or holds the resource.
- mode  in  1  0 = fixed priority (3 highest), 1 = round-robin; sampled only in IDLE.
- gnt  out  4  one-hot grant, registered; 4'b0000 when no grant.
- gnt_id  out  2  binary index of the granted requester; 0 when gnt = 0.
- busy  out  1  high while any grant is active.
- timeout  out  1  one-cycle pulse in the cycle after a grant is revoked by timeout.

Behaviour:
- Reset (synchronous, rst = 1 at a clock edge) values:
  - gnt = 0, gnt_id = 0, busy = 0, timeout = 0.
  - state = IDLE, last_id = 0, hold_cnt = 0, mask = 4'b0000.
  - Reset mid-grant drops the grant at that edge. No partial state survives.
- States:
  - IDLE: no grant.
  - GRANT: gnt/gnt_id/busy held constant.
- IDLE:
  - Candidate vector is cand = req & ~mask.
  - If cand is nonzero, register the winner, set busy = 1, load hold_cnt = 1, and go to GRANT.
  - Grant latency: gnt is visible on the cycle after req is first seen high.
  - If cand = 0, stay in IDLE.
  - mask clears on every IDLE edge, whether or not a grant is issued.
- Winner selection:
  - mode = 0: the highest set index of cand wins (3 > 2 > 1 > 0).
  - mode = 1: search order is (last_id−1), (last_id−2), (last_id−3), last_id, all mod 4. The first set bit of cand in that order wins.
  - After reset last_id = 0, so the round-robin order is 3,2,1,0, identical to fixed mode.
- GRANT, evaluated each edge with owner = gnt_id:
  - Release: if req[owner] = 0, clear gnt/gnt_id/busy, set last_id = owner, and go to IDLE. There is a mandatory one-cycle gap with no grant before the next grant (turnaround).
  - Timeout: if MAX_HOLD ≠ 0, req[owner] = 1 and hold_cnt = MAX_HOLD, then:
    - clear the grant and set last_id = owner;
    - set mask = one-hot(owner) for exactly the next arbitration;
    - pulse timeout = 1 for one cycle;
    - go to IDLE.
  - Otherwise: hold_cnt increments, saturating at MAX_HOLD.
  - If release and timeout coincide, release wins and no timeout pulse is issued.
- Changes to req of non-owners during GRANT have no effect.
- mode changes during GRANT take effect at the next IDLE arbitration.
- Invariants:
  - gnt is one-hot or zero.
  - gnt == (busy ? 1 << gnt_id : 0).
  - No grant persists more than MAX_HOLD cycles when MAX_HOLD ≠ 0.
  - A granted index always had req high in the arbitration cycle.

Test Plan:
- Reset/fixed priority: rst for 2 cycles, then mode = 0, req = 4'b0110 → one cycle later gnt = 0100, gnt_id = 2, busy = 1. Drop req[2] → next cycle gnt = 0, then one cycle later gnt = 0010, gnt_id = 1.
- Round-robin fairness: mode = 1, req = 4'b1111 held; each owner drops its req for one cycle after 3 cycles → grant order 3,2,1,0,3. Exactly one idle cycle separates each grant.
- Timeout, MAX_HOLD = 4: req = 4'b1001 held constant, mode = 0 → gnt = 1000 for exactly 4 cycles, then gnt = 0 with timeout = 1 for 1 cycle, then gnt = 0001 (requester 3 masked). After the next timeout, requester 3 wins again.
- Release/timeout collision, MAX_HOLD = 4: req[3] drops in the same cycle hold_cnt = 4 → gnt clears and timeout stays 0.
- Reset mid-operation: assert rst while gnt = 0100, mode = 1, last_id = 1 → next edge gnt = 0, busy = 0. After release, req = 4'b1010 → grant goes to 3 (last_id reset to 0).
- Idle/no-request: req = 0 for 20 cycles → gnt = 0, busy = 0, timeout = 0 throughout. Single pulse req = 4'b0001 for one cycle → gnt = 0001 for one cycle, then released.
